instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded by reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port PCSrc, input, 1, branch/PC-write taken, from the controller.
REQ-005 SHALL have port Result, input, 32, redirect target (ALU/memory result).
REQ-006 SHALL have port Stall, input, 1, consumer not ready; holds the current instruction.
REQ-007 SHALL have port imem_req, output, 1, instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32, word address of the request.
REQ-009 SHALL have port imem_rdata, input, 32, instruction memory read data.
REQ-010 SHALL have port imem_ready, input, 1, memory accepted the request; rdata valid the same cycle.
REQ-011 SHALL have port Instr, output, 32, registered instruction driven to the controller and datapath.
REQ-012 SHALL have port InstrValid, output, 1, Instr holds a fetched, unconsumed instruction.
REQ-013 SHALL have port PC, output, 32, address of the instruction currently in Instr.
REQ-014 SHALL have port PCPlus8, output, 32, PC+8 (the ARM R15 read value).
REQ-015 SHALL have port InstrCount, output, 32, number of instructions retired.

Function
REQ-016 SHALL implement the FSM states FETCH and VALID.
REQ-017 FETCH: SHALL drive imem_req=1 and imem_addr=PC; on imem_ready=1, SHALL register Instr<=imem_rdata, set InstrValid=1 and enter VALID on the next edge.
REQ-018 FETCH with imem_ready=0: SHALL hold imem_req, imem_addr and PC stable; no timeout.
REQ-019 VALID: SHALL drive imem_req=0 and hold Instr and InstrValid=1.
REQ-020 VALID with Stall=1: SHALL hold all state; PCSrc and Result are ignored.
REQ-021 VALID with Stall=0: the instruction retires; PC<=PCSrc ? {Result[31:2],2'b00} : PC+4; InstrValid<=0; InstrCount+=1; next state FETCH.
REQ-022 PCSrc and Result SHALL be sampled only in VALID with Stall=0.
REQ-023 Minimum issue interval SHALL be 2 cycles (zero-wait memory); fetch-to-Instr latency SHALL be 1 cycle after imem_ready.
REQ-024 PC+4 and PC+8 SHALL wrap modulo 2^32 (e.g. 32'hFFFF_FFFC+4 = 0).
REQ-025 Result[1:0] SHALL be discarded, with no error signalled.
REQ-026 InstrCount SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 imem_rdata SHALL be ignored unless the state is FETCH and imem_ready=1.
REQ-028 PCPlus8 SHALL be combinational from the PC register.

Reset
REQ-029 rst=0 SHALL asynchronously set PC=RESET_PC, Instr=0, InstrValid=0, InstrCount=0 and state FETCH.
REQ-030 While rst=0, imem_req SHALL be 0.
REQ-031 On the first edge after rst deasserts, imem_req=1 SHALL be driven with imem_addr=RESET_PC.
REQ-032 Reset asserted during an outstanding FETCH SHALL abandon the request; the returning data is not captured.

Structure
REQ-033 Package fetch_pkg SHALL hold the state enum, PC_INC=4 and the default RESET_PC.
REQ-034 The PC register with its next-PC mux SHALL be the sub-module pc_register.

Verification
REQ-035 Reset then zero-wait memory with Stall=0: addresses 0,4,8,12 are fetched; InstrValid rises every 2nd cycle; InstrCount=4 after 4 retirements.
REQ-036 imem_ready held low 5 cycles: imem_addr is stable at 0x10 and Instr unchanged; on the ready cycle Instr=rdata on the next edge.
REQ-037 PCSrc=1 with Result=0x0000_0103 at retire: next imem_addr=0x0000_0100.
REQ-038 Stall=1 for 3 cycles in VALID with PCSrc=1 toggling: PC, Instr and InstrCount unchanged; the redirect is taken only on the Stall=0 cycle.
REQ-039 PC=0xFFFF_FFFC retires without branch: next imem_addr=0; PCPlus8 at the wrapped PC=0x0000_0008.
REQ-040 rst pulsed low mid-FETCH: outputs are at reset values asynchronously; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch_state_e (FETCH/VALID), PC_INC, DEFAULT_RESET_PC, align_word().
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary; the low bits are dropped silently.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register with its next-PC mux (sequential PC+4 or aligned redirect).
// Latency: new PC visible one cycle after retire_i; pc_plus8_o is combinational from the PC register.
// Backpressure: PC only moves on retire_i; otherwise it holds.
// Ports: clk_i, rst_ni (async active-low), retire_i, pc_src_i, result_i -> pc_o, pc_plus8_o.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        retire_i,
  input  logic        pc_src_i,
  input  logic [31:0] result_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus8_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Additions wrap naturally modulo 2^32.
  always_comb begin
    pc_d = pc_q;
    if (retire_i) begin
      pc_d = pc_src_i ? align_word(result_i) : (pc_q + PC_INC);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus8_o = pc_q + (PC_INC << 1);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests the word at PC, registers it, and retires it to the consumer.
// Latency: Instr valid one cycle after imem_ready; minimum issue interval 2 cycles.
// Backpressure: Stall holds the current instruction and all state; imem_ready low holds the request.
// Ports: clk, rst (async active-low), PCSrc/Result (redirect), Stall, imem_* (memory side),
//        Instr/InstrValid/PC/PCPlus8/InstrCount (consumer side).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        Stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic [31:0] InstrCount
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  count_q, count_d;
  logic         capture;
  logic         retire;

  assign capture = (state_q == FETCH) && imem_ready;
  assign retire  = (state_q == VALID) && !Stall;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      FETCH: begin
        if (capture) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (retire) begin
          count_d = count_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk_i     (clk),
    .rst_ni    (rst),
    .retire_i  (retire),
    .pc_src_i  (PCSrc),
    .result_i  (Result),
    .pc_o      (PC),
    .pc_plus8_o(PCPlus8)
  );

  // State resets to FETCH, so the request is gated by rst to stay quiet while reset is held.
  assign imem_req   = (state_q == FETCH) && rst;
  assign imem_addr  = PC;
  assign Instr      = instr_q;
  assign InstrValid = (state_q == VALID);
  assign InstrCount = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrc;
  logic [31:0] Result;
  logic        Stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic [31:0] InstrCount;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .PCSrc     (PCSrc),
    .Result    (Result),
    .Stall     (Stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .Instr     (Instr),
    .InstrValid(InstrValid),
    .PC        (PC),
    .PCPlus8   (PCPlus8),
    .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_cyc;
    int          stall_cyc;
    logic        br;
    logic [31:0] res;
    logic [31:0] addr;
    logic [31:0] next;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t        tbl[10];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_count = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE1A0_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch/retire transaction; entered and left in FETCH, 1 time unit after an edge.
  task automatic fetch_one(input int idx, input int wait_cyc, input int stall_cyc, input logic br,
                           input logic [31:0] res, input logic [31:0] addr, input logic [31:0] next);
    logic [31:0] instr_prev, pc_snap, instr_snap, cnt_snap;
    exp_t e;
    chk($sformatf("v%0d req_fetch", idx), {31'd0, imem_req}, 32'd1);
    chk($sformatf("v%0d addr", idx), imem_addr, addr);
    instr_prev = Instr;
    for (int w = 0; w < wait_cyc; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      step();
      chk($sformatf("v%0d wait%0d addr", idx, w), imem_addr, addr);
      chk($sformatf("v%0d wait%0d req", idx, w), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d wait%0d instr", idx, w), Instr, instr_prev);
    end
    imem_ready = 1'b1;
    imem_rdata = mem_word(addr);
    sb.push_back('{pc: addr, instr: mem_word(addr)});
    step();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk($sformatf("v%0d valid", idx), {31'd0, InstrValid}, 32'd1);
    chk($sformatf("v%0d req_valid", idx), {31'd0, imem_req}, 32'd0);
    if (InstrValid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d instr", idx), Instr, e.instr);
      chk($sformatf("v%0d pc", idx), PC, e.pc);
    end else begin
      chk($sformatf("v%0d scoreboard_pop", idx), {31'd0, InstrValid}, 32'd1);
    end
    chk($sformatf("v%0d pcplus8", idx), PCPlus8, addr + 32'd8);
    pc_snap = PC;
    instr_snap = Instr;
    cnt_snap = InstrCount;
    for (int s = 0; s < stall_cyc; s++) begin
      Stall  = 1'b1;
      PCSrc  = s[0] ? 1'b0 : 1'b1;
      Result = $urandom;
      step();
      chk($sformatf("v%0d stall%0d pc", idx, s), PC, pc_snap);
      chk($sformatf("v%0d stall%0d instr", idx, s), Instr, instr_snap);
      chk($sformatf("v%0d stall%0d cnt", idx, s), InstrCount, cnt_snap);
      chk($sformatf("v%0d stall%0d valid", idx, s), {31'd0, InstrValid}, 32'd1);
    end
    Stall  = 1'b0;
    PCSrc  = br;
    Result = res;
    step();
    PCSrc  = 1'b0;
    Result = $urandom;
    exp_count = exp_count + 32'd1;
    chk($sformatf("v%0d retired_valid", idx), {31'd0, InstrValid}, 32'd0);
    chk($sformatf("v%0d next_addr", idx), imem_addr, next);
    chk($sformatf("v%0d next_pcplus8", idx), PCPlus8, next + 32'd8);
    chk($sformatf("v%0d count", idx), InstrCount, exp_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //            wait stall br    res             addr           next
    tbl[0] = '{0, 0, 1'b0, 32'h0,          32'h0000_0000, 32'h0000_0004};
    tbl[1] = '{0, 0, 1'b0, 32'h0,          32'h0000_0004, 32'h0000_0008};
    tbl[2] = '{0, 0, 1'b0, 32'h0,          32'h0000_0008, 32'h0000_000C};
    tbl[3] = '{0, 0, 1'b0, 32'h0,          32'h0000_000C, 32'h0000_0010};
    tbl[4] = '{5, 0, 1'b0, 32'h0,          32'h0000_0010, 32'h0000_0014};
    tbl[5] = '{0, 0, 1'b1, 32'h0000_0103,  32'h0000_0014, 32'h0000_0100};
    tbl[6] = '{0, 3, 1'b1, 32'h0000_0200,  32'h0000_0100, 32'h0000_0200};
    tbl[7] = '{1, 0, 1'b1, 32'hFFFF_FFFF,  32'h0000_0200, 32'hFFFF_FFFC};
    tbl[8] = '{0, 0, 1'b0, 32'h0,          32'hFFFF_FFFC, 32'h0000_0000};
    tbl[9] = '{2, 1, 1'b0, 32'h0,          32'h0000_0000, 32'h0000_0004};

    rst        = 1'b0;
    PCSrc      = 1'b0;
    Result     = 32'h0;
    Stall      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    #1;
    chk("rst req", {31'd0, imem_req}, 32'd0);
    chk("rst pc", PC, 32'h0);
    chk("rst instr", Instr, 32'h0);
    chk("rst valid", {31'd0, InstrValid}, 32'd0);
    chk("rst count", InstrCount, 32'h0);
    chk("rst pcplus8", PCPlus8, 32'h8);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("release req", {31'd0, imem_req}, 32'd1);
    chk("release addr", imem_addr, 32'h0);
    step();

    for (int i = 0; i < 10; i++) begin
      fetch_one(i, tbl[i].wait_cyc, tbl[i].stall_cyc, tbl[i].br, tbl[i].res, tbl[i].addr, tbl[i].next);
      if (i == 3) chk("count_after_4", InstrCount, 32'd4);
    end

    // Reset asserted mid-cycle while a fetch to 0x4 is outstanding.
    imem_ready = 1'b0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("midrst req", {31'd0, imem_req}, 32'd0);
    chk("midrst pc", PC, 32'h0);
    chk("midrst instr", Instr, 32'h0);
    chk("midrst valid", {31'd0, InstrValid}, 32'd0);
    chk("midrst count", InstrCount, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("midrst no_capture", Instr, 32'h0);
    chk("midrst still_idle", {31'd0, InstrValid}, 32'd0);
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("after_rst req", {31'd0, imem_req}, 32'd1);
    chk("after_rst addr", imem_addr, 32'h0);
    chk("after_rst instr", Instr, 32'h0);
    step();
    exp_count = 32'd0;
    fetch_one(10, 0, 0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0004);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
